// File: rtl/bch_pkg.sv
// Shared types and constants for the bch pattern driver and its cycle timer.
package bch_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StSet,
        StRun,
        StGap,
        StDone
    } state_t;

    localparam logic [1:0] CODE_63   = 2'd1;
    localparam logic [1:0] CODE_255  = 2'd2;
    localparam logic [1:0] CODE_1023 = 2'd3;

    localparam logic MODE_HARD = 1'b0;
    localparam logic MODE_SOFT = 1'b1;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/bch_pattern_driver_if.sv
// Handshake bundle between the pattern driver (master) and the bch decoder (slave).
interface bch_pattern_driver_if #(
    parameter int unsigned IDATA_W = 64,
    parameter int unsigned ODATA_W = 10
);
    logic               mode;
    logic [1:0]         code;
    logic               set;
    logic [IDATA_W-1:0] idata;
    logic               ready;
    logic               finish;
    logic [ODATA_W-1:0] odata;

    modport master (
        output mode, code, set, idata,
        input  ready, finish, odata
    );

    modport slave (
        input  mode, code, set, idata,
        output ready, finish, odata
    );
endinterface

// File: rtl/bch_cycle_timer.sv
// Shared watchdog / inter-test gap counter; expires on a run cycle whose count hits the limit.
module bch_cycle_timer #(
    parameter int unsigned W = 20
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         i_load,
    input  logic         i_run,
    input  logic [W-1:0] i_limit,
    output logic         o_expire
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= '0;
        end else if (i_run) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_expire = i_run && (r_cnt == i_limit);

endmodule

// File: rtl/bch_pattern_driver.sv
// Replays stored codewords into the bch decoder, checks its output beats against golden data
// and keeps error, test and watchdog-timeout statistics.
module bch_pattern_driver
    import bch_pkg::*;
#(
    parameter int unsigned IDATA_W = 64,
    parameter int unsigned ODATA_W = 10,
    parameter int unsigned PAT_AW  = 15,
    parameter int unsigned GOLD_AW = 17,
    parameter int unsigned NTEST_W = 16,
    parameter int unsigned GAP_CYC = 10,
    parameter int unsigned TMO_W   = 20
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                i_start,
    input  logic                i_cfg_mode,
    input  logic [1:0]          i_cfg_code,
    input  logic [NTEST_W-1:0]  i_cfg_ntest,
    output logic [PAT_AW-1:0]   o_pat_addr,
    input  logic [IDATA_W-1:0]  i_pat_rdata,
    output logic [GOLD_AW-1:0]  o_gold_addr,
    input  logic [ODATA_W-1:0]  i_gold_rdata,
    bch_pattern_driver_if.master dut_if,
    output logic                o_busy,
    output logic                o_done,
    output logic [NTEST_W-1:0]  o_test_cnt,
    output logic [15:0]         o_err_cnt,
    output logic [NTEST_W-1:0]  o_tmo_cnt,
    output logic [NTEST_W-1:0]  o_first_fail
);

    // Watchdog fires on the RUN cycle where 2^TMO_W-1 cycles have elapsed.
    localparam logic [TMO_W-1:0]   TMO_LIM = {{(TMO_W - 1){1'b1}}, 1'b0};
    localparam logic [TMO_W-1:0]   GAP_LIM = TMO_W'(GAP_CYC - 1);
    localparam logic [NTEST_W-1:0] FF_NONE = '1;

    state_t r_state, w_state_d;

    logic [NTEST_W-1:0] r_ntest;
    logic [NTEST_W-1:0] r_test_cnt;
    logic [NTEST_W-1:0] r_tmo_cnt;
    logic [NTEST_W-1:0] r_first_fail;
    logic [15:0]        r_err_cnt;
    logic [PAT_AW-1:0]  r_pat_addr;
    logic [GOLD_AW-1:0] r_gold_addr;
    logic [IDATA_W-1:0] r_idata;
    logic               r_mode;
    logic [1:0]         r_code;
    logic               r_fin_seen;

    logic               w_in_run;
    logic               w_in_gap;
    logic               w_launch;
    logic               w_take;
    logic               w_beat;
    logic               w_mis;
    logic               w_end;
    logic               w_abort;
    logic               w_expire;
    logic               w_tmr_load;
    logic               w_tmr_run;
    logic [TMO_W-1:0]   w_tmr_limit;

    assign w_in_run = (r_state == StRun);
    assign w_in_gap = (r_state == StGap);
    assign w_launch = (r_state == StIdle) && i_start;
    assign w_take   = (w_in_run || w_in_gap) && dut_if.ready;
    assign w_beat   = w_in_run && dut_if.finish;
    assign w_mis    = w_beat && (dut_if.odata != i_gold_rdata);
    assign w_end    = w_in_run && r_fin_seen && !dut_if.finish;
    assign w_abort  = w_in_run && !r_fin_seen && !dut_if.finish && w_expire;

    assign w_tmr_load  = (r_state == StSet) || w_end || w_abort;
    assign w_tmr_run   = w_in_run || w_in_gap;
    assign w_tmr_limit = w_in_run ? TMO_LIM : GAP_LIM;

    bch_cycle_timer #(
        .W (TMO_W)
    ) u_timer (
        .clk      (clk),
        .rstn     (rstn),
        .i_load   (w_tmr_load),
        .i_run    (w_tmr_run),
        .i_limit  (w_tmr_limit),
        .o_expire (w_expire)
    );

    always_comb begin
        w_state_d = r_state;
        case (r_state)
            StIdle: begin
                if (i_start) begin
                    w_state_d = (i_cfg_ntest == '0) ? StDone : StSet;
                end
            end
            StSet:  w_state_d = StRun;
            StRun: begin
                if (w_end || w_abort) begin
                    w_state_d = StGap;
                end
            end
            StGap: begin
                if (w_expire) begin
                    w_state_d = (r_test_cnt < r_ntest) ? StSet : StDone;
                end
            end
            StDone:  w_state_d = StIdle;
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_ntest      <= '0;
            r_test_cnt   <= '0;
            r_tmo_cnt    <= '0;
            r_first_fail <= FF_NONE;
            r_err_cnt    <= '0;
            r_pat_addr   <= '0;
            r_gold_addr  <= '0;
            r_idata      <= '0;
            r_mode       <= MODE_HARD;
            r_code       <= 2'b00;
            r_fin_seen   <= 1'b0;
        end else if (w_launch) begin
            r_ntest      <= i_cfg_ntest;
            r_mode       <= i_cfg_mode;
            r_code       <= i_cfg_code;
            r_test_cnt   <= '0;
            r_tmo_cnt    <= '0;
            r_first_fail <= FF_NONE;
            r_err_cnt    <= '0;
            r_pat_addr   <= '0;
            r_gold_addr  <= '0;
            r_fin_seen   <= 1'b0;
        end else begin
            if (w_take) begin
                r_idata    <= i_pat_rdata;
                r_pat_addr <= r_pat_addr + 1'b1;
            end
            if (r_state == StSet) begin
                r_fin_seen <= 1'b0;
            end else if (w_beat) begin
                r_fin_seen  <= 1'b1;
                r_gold_addr <= r_gold_addr + 1'b1;
            end
            if (w_mis || w_abort) begin
                r_err_cnt <= sat_inc16(r_err_cnt);
                if (r_first_fail == FF_NONE) begin
                    r_first_fail <= r_test_cnt;
                end
            end
            if (w_end || w_abort) begin
                r_test_cnt <= r_test_cnt + 1'b1;
            end
            if (w_abort) begin
                r_tmo_cnt <= r_tmo_cnt + 1'b1;
            end
        end
    end

    assign dut_if.mode  = r_mode;
    assign dut_if.code  = r_code;
    assign dut_if.set   = (r_state == StSet);
    assign dut_if.idata = r_idata;

    assign o_pat_addr   = r_pat_addr;
    assign o_gold_addr  = r_gold_addr;
    assign o_busy       = (r_state == StSet) || w_in_run || w_in_gap;
    assign o_done       = (r_state == StDone);
    assign o_test_cnt   = r_test_cnt;
    assign o_err_cnt    = r_err_cnt;
    assign o_tmo_cnt    = r_tmo_cnt;
    assign o_first_fail = r_first_fail;

endmodule

// File: doc/bch_pattern_driver.md
# bch_pattern_driver

Synthesizable stimulus/checker engine for the `bch` decoder. It replays stored 64-bit codeword words into the decoder whenever `ready` is raised. It compares every `odata` beat during `finish` against stored golden values, and accumulates error, test and timeout statistics. It sits beside `bch` in the on-chip self-test wrapper and generalises the simulation bench flow to parametrised widths, depths, test counts, inter-test gaps and a per-test watchdog.

## Interface
Parameters:
- IDATA_W, 64, decoder input word width
- ODATA_W, 10, decoder output width
- PAT_AW, 15, pattern memory address width
- GOLD_AW, 17, golden memory address width
- NTEST_W, 16, test-count width
- GAP_CYC, 10, idle cycles between the end of one test and the next `set`
- TMO_W, 20, watchdog width; timeout fires after 2^TMO_W−1 cycles

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  clock
- rstn  in  1  async active-low reset
- start  in  1  one-cycle pulse that launches a run; ignored while busy
- cfg_mode  in  1  0 = hard decision, 1 = soft decision; sampled at start
- cfg_code  in  2  code select (1 = 63, 2 = 255, 3 = 1023); sampled at start
- cfg_ntest  in  NTEST_W  number of tests; 0 means done immediately
- pat_addr  out  PAT_AW  pattern memory address
- pat_rdata  in  IDATA_W  mem[pat_addr], combinational read
- gold_addr  out  GOLD_AW  golden memory address
- gold_rdata  in  ODATA_W  mem[gold_addr], combinational read
- dut_mode  out  1  registered copy of cfg_mode
- dut_code  out  2  registered copy of cfg_code
- dut_set  out  1  one-cycle set pulse per test
- dut_idata  out  IDATA_W  decoder input word
- dut_ready  in  1  decoder requests the next word
- dut_finish  in  1  decoder output beat valid
- dut_odata  in  ODATA_W  decoder output beat
- busy  out  1  run in progress
- done  out  1  one-cycle pulse at end of run
- test_cnt  out  NTEST_W  tests completed
- err_cnt  out  16  mismatches plus timeouts, saturating at 0xFFFF
- tmo_cnt  out  NTEST_W  tests aborted by the watchdog
- first_fail  out  NTEST_W  index of the first failing test; all-ones if none

## Operation
- Reset values: all address and counter outputs are 0. `dut_set`, `busy` and `done` are 0. `dut_idata` is 0. `first_fail` is all-ones. `dut_mode` and `dut_code` are 0.
- FSM states: IDLE, SET, RUN, GAP, DONE.
- IDLE: on `start`, latch `cfg_*`, clear all counters and addresses, set `first_fail` to all-ones, and go to SET. If `cfg_ntest` is 0, go to DONE instead.
- SET: drive `dut_set` = 1 for exactly one cycle, clear the watchdog, go to RUN.
- RUN, input side: on any cycle with `dut_ready` = 1, `dut_idata` <= `pat_rdata` and `pat_addr` <= `pat_addr` + 1. Back-to-back ready cycles consume consecutive words.
- RUN, output side: on any cycle with `dut_finish` = 1, compare `dut_odata` with `gold_rdata` and increment `gold_addr`.
  - On a mismatch: increment `err_cnt` (saturating). If `first_fail` is still all-ones, load it with `test_cnt`.
- RUN, end of test: on the first cycle with `dut_finish` = 0 after a cycle with `dut_finish` = 1, increment `test_cnt` and go to GAP.
- RUN, watchdog: the watchdog increments every RUN cycle. If it reaches all-ones before any finish, the test is aborted:
  - increment `tmo_cnt` and `err_cnt`, capture `first_fail`, increment `test_cnt`, go to GAP;
  - do not advance `gold_addr`; golden alignment is the software's concern.
- GAP: count GAP_CYC cycles. Then go to SET if `test_cnt` < the latched ntest, else go to DONE. `dut_ready` is still honoured in GAP; `dut_finish` is ignored.
- DONE: pulse `done` for one cycle, drop `busy`, return to IDLE. All counters hold their values until the next `start`.
- Address wrap: `pat_addr` and `gold_addr` wrap modulo 2^AW without a flag.
- Reset asserted mid-run: every output returns to its reset value asynchronously, and no `done` is issued.

## Timing
- `start` to `dut_set`: 1 cycle (IDLE→SET registered). `busy` rises in the same cycle as `dut_set`.
- Ready response: `dut_ready` sampled high at edge k gives new `dut_idata` valid after edge k.
- Compare is same-cycle combinational. The counter update is visible 1 cycle after the finish beat.
- Last finish beat to next `dut_set`: GAP_CYC + 2 cycles.
- `dut_set` coincident with `dut_finish` cannot occur, because SET is only entered from GAP or IDLE.

## Structure
- Shared package `bch_pkg`: FSM state enum, code constants (CODE_63 = 1, CODE_255 = 2, CODE_1023 = 3), and mode constants.
- The watchdog plus gap counter is natural as one sub-module, `bch_cycle_timer`, with load, run and expire signals.

## Test plan
- ntest = 1, code = 1, mode = 0, decoder model raises ready for 1 cycle and then finish for 2 beats matching golden → `err_cnt` = 0, `test_cnt` = 1, one `done` pulse, `first_fail` = all-ones.
- ntest = 3, with the second test's second beat corrupted → `err_cnt` = 1, `first_fail` = 1, `gold_addr` = 6.
- Ready held high for 4 consecutive cycles → `dut_idata` steps through pat[0..3] on consecutive cycles, and `pat_addr` = 4.
- Decoder never finishes, TMO_W = 4 → abort after 15 RUN cycles, `tmo_cnt` = 1, `err_cnt` = 1, next `dut_set` after GAP_CYC + 1 cycles.
- `start` during busy, and `cfg_ntest` = 0 → the first is ignored; the second gives `done` 1 cycle after `start` with no `dut_set`.
- rstn dropped mid-RUN → all outputs return to reset values immediately, and a subsequent `start` runs cleanly from address 0.
